// File: rtl/pb_pkg.sv
// Shared opcode encodings and helpers for the pb execution unit.
package pb_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd5;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd6;
    localparam logic [OP_W-1:0] OP_MOV  = 4'd7;
    localparam logic [OP_W-1:0] OP_MINU = 4'd8;
    localparam logic [OP_W-1:0] OP_MAXU = 4'd9;

    // Everything above MAXU retires as an error without touching the register file.
    function automatic logic op_reserved(logic [OP_W-1:0] op);
        return op > OP_MAXU;
    endfunction

endpackage

// File: rtl/pb_exec_unit_if.sv
// Sequencer/host-facing bundle of the pb execution unit.
interface pb_exec_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic                   instr_valid;
    logic                   instr_ready;
    logic [pb_pkg::OP_W-1:0] instr_op;
    logic [ADDR_W-1:0]      instr_rd;
    logic [ADDR_W-1:0]      instr_rs1;
    logic [ADDR_W-1:0]      instr_rs2;

    logic                   ext_wr_en;
    logic                   ext_wr_ready;
    logic [ADDR_W-1:0]      ext_wr_addr;
    logic [DATA_W-1:0]      ext_wr_data;

    logic [ADDR_W-1:0]      dbg_rd_addr;
    logic [DATA_W-1:0]      dbg_rd_data;

    logic                   res_valid;
    logic [ADDR_W-1:0]      res_rd;
    logic [DATA_W-1:0]      res_data;
    logic                   res_err;
    logic                   busy;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        output ext_wr_en, ext_wr_addr, ext_wr_data, dbg_rd_addr,
        input  instr_ready, ext_wr_ready, dbg_rd_data,
        input  res_valid, res_rd, res_data, res_err, busy
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        input  ext_wr_en, ext_wr_addr, ext_wr_data, dbg_rd_addr,
        output instr_ready, ext_wr_ready, dbg_rd_data,
        output res_valid, res_rd, res_data, res_err, busy
    );

endinterface

// File: rtl/pb_alu_pipe.sv
// Fixed-latency ALU: computes at issue, then carries {valid,rd,data,err}
// through ALU_LAT register stages so the result appears ALU_LAT cycles later.
module pb_alu_pipe
    import pb_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned ALU_LAT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              busy
);

    localparam int unsigned SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] alu_res;
    logic              alu_err;
    logic [SH_W-1:0]   sh_amt;

    logic [ALU_LAT-1:0] vld_q;
    logic [ALU_LAT-1:0] err_q;
    logic [ADDR_W-1:0]  rd_q   [ALU_LAT];
    logic [DATA_W-1:0]  data_q [ALU_LAT];

    // Stage-0 combinational ALU; reserved opcodes yield data 0 with err set.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        sh_amt  = in_b[SH_W-1:0];
        case (in_op)
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  alu_res = in_a - in_b;
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_SHL:  alu_res = in_a << sh_amt;
            OP_SHR:  alu_res = in_a >> sh_amt;
            OP_MOV:  alu_res = in_a;
            OP_MINU: alu_res = (in_a < in_b) ? in_a : in_b;
            OP_MAXU: alu_res = (in_a < in_b) ? in_b : in_a;
            default: alu_err = 1'b1;
        endcase
    end

    // Payload is zeroed when no op enters so idle result lines read 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < int'(ALU_LAT); i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= in_valid;
            err_q[0]  <= in_valid & alu_err;
            rd_q[0]   <= in_valid ? in_rd : '0;
            data_q[0] <= in_valid ? alu_res : '0;
            for (int i = 1; i < int'(ALU_LAT); i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                rd_q[i]   <= rd_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[ALU_LAT-1];
    assign out_err   = err_q[ALU_LAT-1];
    assign out_rd    = rd_q[ALU_LAT-1];
    assign out_data  = data_q[ALU_LAT-1];
    assign busy      = |vld_q;

endmodule

// File: rtl/pb_exec_unit.sv
// Register file + scoreboarded issue into a fixed-latency ALU with automatic
// writeback, plus a host load port that only commits while the pipe is empty.
module pb_exec_unit
    import pb_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned ALU_LAT  = 3
) (
    input  logic          clock,
    input  logic          reset,
    pb_exec_unit_if.slave bus
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending_q;
    logic [DEPTH-1:0]  pending_nxt;

    logic              host_wr;
    logic              issue;
    logic              ret_wr;
    logic              pipe_busy;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    function automatic logic in_range(logic [ADDR_W-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    // Handshake: host load wins over issue, and both are held off during reset.
    always_comb begin
        bus.ext_wr_ready = reset && !pipe_busy && (pending_q == '0);
        host_wr          = bus.ext_wr_en && bus.ext_wr_ready;
        bus.instr_ready  = reset
                           && !pending_q[bus.instr_rs1]
                           && !pending_q[bus.instr_rs2]
                           && !pending_q[bus.instr_rd]
                           && !host_wr;
        issue            = bus.instr_valid && bus.instr_ready;
        bus.busy         = pipe_busy;
        ret_wr           = bus.res_valid && !bus.res_err && in_range(bus.res_rd);
    end

    assign rs1_data        = regs[bus.instr_rs1];
    assign rs2_data        = regs[bus.instr_rs2];
    assign bus.dbg_rd_data = regs[bus.dbg_rd_addr];

    // Retire clears before issue sets; an issuing rd can never be the retiring one.
    always_comb begin
        pending_nxt = pending_q;
        if (bus.res_valid) begin
            pending_nxt[bus.res_rd] = 1'b0;
        end
        if (issue) begin
            pending_nxt[bus.instr_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_nxt;
        end
    end

    // Host and writeback never coincide: host writes need an empty pipe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (host_wr) begin
            if (in_range(bus.ext_wr_addr)) begin
                regs[bus.ext_wr_addr] <= bus.ext_wr_data;
            end
        end else if (ret_wr) begin
            regs[bus.res_rd] <= bus.res_data;
        end
    end

    pb_alu_pipe #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ALU_LAT (ALU_LAT)
    ) u_alu_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (issue),
        .in_op     (bus.instr_op),
        .in_rd     (bus.instr_rd),
        .in_a      (rs1_data),
        .in_b      (rs2_data),
        .out_valid (bus.res_valid),
        .out_rd    (bus.res_rd),
        .out_data  (bus.res_data),
        .out_err   (bus.res_err),
        .busy      (pipe_busy)
    );

endmodule
